sd_data_fifo: RTL and testbench



---
 rtl/sdfm_pkg.sv | 8 +
 rtl/sd_data_fifo_if.sv | 27 ++
 rtl/sd_fifo_ram.sv | 20 ++
 rtl/sd_data_fifo.sv | 64 ++++++
 tb/tb_sd_data_fifo.sv | 136 +++++++++++++
 5 files changed

// File: rtl/sdfm_pkg.sv
// sdfm_pkg: shared widths, default FIFO depth and count-width helper for the sigma-delta channel.
package sdfm_pkg;
  localparam int SDFM_DATA_W = 32;
  localparam int SDFM_FIFO_DEPTH = 16;
  function automatic int sdfm_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/sd_data_fifo_if.sv
// sd_data_fifo_if: filter sample input, register controls and FIFO status for one channel.
interface sd_data_fifo_if
  import sdfm_pkg::*;
#(
  parameter int CNT_W = sdfm_cnt_w(SDFM_FIFO_DEPTH)
);
  logic [SDFM_DATA_W-1:0] filt_data_in;
  logic                   filt_data_update;
  logic                   reg_fifoen;
  logic [CNT_W-1:0]       reg_fifolvl;
  logic                   fifo_clr;
  logic                   fifo_rd;
  logic [SDFM_DATA_W-1:0] fifo_data;
  logic [CNT_W-1:0]       fifo_cnt;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic                   fifo_ovf;
  logic                   fifo_int;
  modport master (
    output filt_data_in, filt_data_update, reg_fifoen, reg_fifolvl, fifo_clr, fifo_rd,
    input  fifo_data, fifo_cnt, fifo_empty, fifo_full, fifo_ovf, fifo_int
  );
  modport slave (
    input  filt_data_in, filt_data_update, reg_fifoen, reg_fifolvl, fifo_clr, fifo_rd,
    output fifo_data, fifo_cnt, fifo_empty, fifo_full, fifo_ovf, fifo_int
  );
endinterface

// File: rtl/sd_fifo_ram.sv
// sd_fifo_ram: unreset DEPTH x 32 storage, synchronous write, asynchronous read.
module sd_fifo_ram
  import sdfm_pkg::*;
#(
  parameter int DEPTH = SDFM_FIFO_DEPTH,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [SDFM_DATA_W-1:0] wdata,
  input  logic [AW-1:0]          raddr,
  output logic [SDFM_DATA_W-1:0] rdata
);
  logic [SDFM_DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/sd_data_fifo.sv
// sd_data_fifo: per-channel first-word-fall-through result FIFO with level/overflow interrupt.
// Define SDFM_FIFO_OVERWRITE_EN to replace the oldest entry on a write while full.
module sd_data_fifo
  import sdfm_pkg::*;
#(
  parameter int DEPTH = SDFM_FIFO_DEPTH,
  parameter int CNT_W = sdfm_cnt_w(DEPTH)
) (
  input  logic        SYSCLK,
  input  logic        SYSRST,
  sd_data_fifo_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       cnt;
  logic                   ovf, irq;
  logic                   flush, wr_req, pop, full, empty, we, adv_rd;
  logic [SDFM_DATA_W-1:0] rd_data;
  assign empty  = cnt == '0;
  assign full   = cnt == CNT_W'(DEPTH);
  assign flush  = bus.fifo_clr | ~bus.reg_fifoen;
  assign wr_req = bus.filt_data_update & bus.reg_fifoen & ~bus.fifo_clr;
  assign pop    = bus.fifo_rd & ~empty;
`ifdef SDFM_FIFO_OVERWRITE_EN
  assign we = wr_req;
`else
  assign we = wr_req & (~full | pop);
`endif
  // a write landing on a full FIFO without a pop evicts the head
  assign adv_rd = pop | (we & full);
  always_ff @(posedge SYSCLK) begin
    if (SYSRST || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (we) wr_ptr <= wr_ptr + PW'(1);
      if (adv_rd) rd_ptr <= rd_ptr + PW'(1);
      if (we && !adv_rd) cnt <= cnt + CNT_W'(1);
      else if (adv_rd && !we) cnt <= cnt - CNT_W'(1);
      if (wr_req && full && !pop) ovf <= 1'b1;
    end
  end
  // a flush also drops the pending interrupt so it cannot outlive the cleared state
  always_ff @(posedge SYSCLK) begin
    if (SYSRST) irq <= 1'b0;
    else irq <= ~flush & (((bus.reg_fifolvl != '0) && (cnt >= bus.reg_fifolvl)) | ovf);
  end
  sd_fifo_ram #(.DEPTH(DEPTH)) u_ram (
    .clk  (SYSCLK),
    .we   (we),
    .waddr(wr_ptr),
    .wdata(bus.filt_data_in),
    .raddr(rd_ptr),
    .rdata(rd_data)
  );
  assign bus.fifo_data  = empty ? '0 : rd_data;
  assign bus.fifo_cnt   = cnt;
  assign bus.fifo_empty = empty;
  assign bus.fifo_full  = full;
  assign bus.fifo_ovf   = ovf;
  assign bus.fifo_int   = irq;
endmodule

// File: tb/tb_sd_data_fifo.sv
// tb_sd_data_fifo: queue-scoreboard bench for sd_data_fifo, honours SDFM_FIFO_OVERWRITE_EN.
module tb_sd_data_fifo;
  import sdfm_pkg::*;
  localparam int DEPTH = 16;
  localparam int CNT_W = sdfm_cnt_w(DEPTH);
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  sd_data_fifo_if #(.CNT_W(CNT_W)) bus ();
  sd_data_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .SYSCLK(clk),
    .SYSRST(rst),
    .bus   (bus)
  );
  logic [31:0] q[$];
  bit m_ovf, m_int;
  int n_vec, n_err;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic check_state();
    check("cnt", 32'(bus.fifo_cnt), 32'(q.size()));
    check("data", bus.fifo_data, q.size() > 0 ? q[0] : 32'h0);
    check("empty", 32'(bus.fifo_empty), 32'(q.size() == 0));
    check("full", 32'(bus.fifo_full), 32'(q.size() == DEPTH));
    check("ovf", 32'(bus.fifo_ovf), 32'(m_ovf));
    check("int", 32'(bus.fifo_int), 32'(m_int));
  endtask
  task automatic cyc(input bit upd, input logic [31:0] d, input bit rd, input bit clr = 1'b0,
                     input bit r = 1'b0);
    bit flush, nint;
    bus.filt_data_in = d;
    bus.filt_data_update = upd;
    bus.fifo_rd = rd;
    bus.fifo_clr = clr;
    rst = r;
    flush = clr || !bus.reg_fifoen;
    if (rd && q.size() > 0 && !flush && !r) check("pop_data", bus.fifo_data, q[0]);
    nint = !r && !flush && ((bus.reg_fifolvl != 0 && q.size() >= int'(bus.reg_fifolvl)) || m_ovf);
    if (r || flush) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      if (rd && q.size() > 0) void'(q.pop_front());
      if (upd) begin
        if (q.size() < DEPTH) q.push_back(d);
        else begin
          m_ovf = 1'b1;
`ifdef SDFM_FIFO_OVERWRITE_EN
          void'(q.pop_front());
          q.push_back(d);
`endif
        end
      end
    end
    m_int = nint;
    @(posedge clk);
    #1;
    bus.filt_data_update = 1'b0;
    bus.fifo_rd = 1'b0;
    bus.fifo_clr = 1'b0;
    rst = 1'b0;
    check_state();
  endtask
  initial begin
    bus.reg_fifoen = 1'b1;
    bus.reg_fifolvl = '0;
    bus.filt_data_in = '0;
    bus.filt_data_update = 1'b0;
    bus.fifo_rd = 1'b0;
    bus.fifo_clr = 1'b0;
    rst = 1'b1;
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    check("rst_empty", 32'(bus.fifo_empty), 32'd1);
    cyc(1, 32'h11, 0);
    cyc(1, 32'h22, 0);
    check("cnt_two", 32'(bus.fifo_cnt), 32'd2);
    check("head_11", bus.fifo_data, 32'h11);
    cyc(0, 0, 1);
    check("head_22", bus.fifo_data, 32'h22);
    cyc(0, 0, 1);
    check("drained", 32'(bus.fifo_empty), 32'd1);
    cyc(0, 0, 1);
    for (int i = 1; i <= DEPTH; i++) cyc(1, 32'(i), 0);
    check("full16", 32'(bus.fifo_full), 32'd1);
    cyc(1, 32'h100, 1);
    check("wrpop_cnt", 32'(bus.fifo_cnt), 32'd16);
    check("wrpop_ovf", 32'(bus.fifo_ovf), 32'd0);
    for (int i = 0; i < DEPTH; i++) cyc(0, 0, 1);
    for (int i = 1; i <= DEPTH; i++) cyc(1, 32'(i), 0);
    cyc(1, 32'd17, 0);
    check("ovf_set", 32'(bus.fifo_ovf), 32'd1);
`ifdef SDFM_FIFO_OVERWRITE_EN
    check("ovf_head", bus.fifo_data, 32'd2);
`else
    check("ovf_head", bus.fifo_data, 32'd1);
`endif
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(1, 32'h55, 0, 1);
    check("clr_cnt", 32'(bus.fifo_cnt), 32'd0);
    check("clr_int", 32'(bus.fifo_int), 32'd0);
    for (int i = 1; i <= DEPTH; i++) cyc(1, 32'(i + 40), 0);
    cyc(1, 32'd99, 0);
    for (int i = 0; i < DEPTH; i++) cyc(0, 0, 1);
    cyc(0, 0, 0, 1);
    bus.reg_fifolvl = CNT_W'(4);
    for (int i = 1; i <= 4; i++) cyc(1, 32'(i + 200), 0);
    check("lvl_lag", 32'(bus.fifo_int), 32'd0);
    cyc(0, 0, 0);
    check("lvl_rise", 32'(bus.fifo_int), 32'd1);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    check("lvl_fall", 32'(bus.fifo_int), 32'd0);
    bus.reg_fifolvl = CNT_W'(20);
    for (int i = 0; i < 14; i++) cyc(1, $urandom, $urandom_range(0, 1) == 1);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    bus.reg_fifoen = 1'b0;
    cyc(1, 32'h77, 0);
    bus.reg_fifoen = 1'b1;
    bus.reg_fifolvl = CNT_W'(3);
    for (int i = 0; i < 5; i++) cyc(1, 32'(i + 300), 0);
    cyc(1, 32'h9, 0, 0, 1);
    check("rst_cnt", 32'(bus.fifo_cnt), 32'd0);
    check("rst_int", 32'(bus.fifo_int), 32'd0);
    cyc(0, 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
